adder_ctrl: RTL

ADDER_CTRL -- requirements
Module: adder_ctrl

---
 rtl/adder_ctrl_pkg.sv | 34 +++
 rtl/adder_ctrl_wdog.sv | 40 ++++
 rtl/adder_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/adder_ctrl_pkg.sv
// adder_ctrl_pkg
// Types and helpers shared by the adder controller:
//   state_e          - controller FSM states (IDLE, ISSUE, DRAIN, DONE)
//   WS_3X3/5X5/7X7   - kernel size codes carried on cfg_wsize / wsize
//   rounds_per_tile  - adder rounds needed per MUL result tile for a given
//                      kernel code and stride
package adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [3:0] WS_3X3 = 4'd0;
    localparam logic [3:0] WS_5X5 = 4'd1;
    localparam logic [3:0] WS_7X7 = 4'd2;

    // Larger kernels need more passes through the adder tree; stride 2
    // halves the work for the two larger kernels.
    function automatic logic [2:0] rounds_per_tile(input logic [3:0] ws,
                                                   input logic       st);
        logic [2:0] r;
        r = 3'd1;
        case (ws)
            WS_5X5:  r = st ? 3'd1 : 3'd2;
            WS_7X7:  r = st ? 3'd2 : 3'd4;
            default: r = 3'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/adder_ctrl_wdog.sv
// adder_ctrl_wdog
// Consecutive-cycle counter used as the DRAIN watchdog of adder_ctrl.
// Only present when ADDER_CTRL_WDOG_EN is defined; without the macro this
// file elaborates to nothing so it never shows up as a stray top module.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - restart the count (leaving DRAIN or a Psum arrived)
//   en        - count this cycle
//   expire    - high during the TIMEOUT-th consecutive counted cycle
`ifdef ADDER_CTRL_WDOG_EN
module adder_ctrl_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // cnt holds the number of earlier silent cycles, so this cycle is the
    // TIMEOUT-th one when cnt has reached TIMEOUT-1.
    assign expire = en && (cnt == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/adder_ctrl.sv
// adder_ctrl
// Sequences MUL result tiles into the adder: latches a layer config, issues
// R rounds per tile (R from kernel size and stride), limits tiles in flight
// to MAX_OUT by counting returned Psum_valid pulses, and signals layer
// completion.
// Optional feature: define ADDER_CTRL_WDOG_EN to add a DRAIN watchdog that
// flags err and ends the layer after TIMEOUT cycles without Psum_valid.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   cfg_valid/cfg_ready      - layer config handshake
//   cfg_wsize/stride/tiles   - kernel code, stride, tile count
//   mul_avail / mul_ack      - upstream tile available / tile consumed
//   wsize, stride, wround,
//   MUL_DATA_valid           - round control to the adder
//   Psum_valid               - adder finished one tile
//   busy, done, err          - status
//
// Handshakes: a config transfers on a rising edge where cfg_valid and
// cfg_ready are both high; cfg_ready is high exactly while in IDLE and
// cfg_valid in any other state is ignored. A tile is taken from upstream on
// the edge where mul_avail is sampled high with credit available; mul_ack
// marks the last round of that tile, after which upstream may advance.
module adder_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [3:0] cfg_wsize,
    input  logic       cfg_stride,
    input  logic [7:0] cfg_tiles,
    input  logic       mul_avail,
    output logic       mul_ack,
    output logic [3:0] wsize,
    output logic       stride,
    output logic [2:0] wround,
    output logic       MUL_DATA_valid,
    input  logic       Psum_valid,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // Outstanding is a 3-bit counter that must never wrap.
    if (MAX_OUT < 1 || MAX_OUT > 7) begin : g_bad_max_out
        $error("adder_ctrl: MAX_OUT must be in 1..7");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("adder_ctrl: TIMEOUT must be at least 2");
    end

    state_e     state;
    logic [7:0] tiles_q;
    logic [7:0] issued_q;
    logic [7:0] rcvd_q;
    logic [2:0] outst_q;
    logic [2:0] rounds_q;

    logic       psum_ok;
    logic [3:0] out_nxt;
    logic [7:0] iss_nxt;
    logic [7:0] rcv_nxt;
    logic       credit_ok;
    logic       wdog_expire;

    // Counter updates for this edge. mul_ack is registered, so it marks the
    // tile being completed in the current cycle.
    always_comb begin
        psum_ok   = Psum_valid && (outst_q != 3'd0);
        out_nxt   = {1'b0, outst_q} + {3'b000, mul_ack} - {3'b000, psum_ok};
        iss_nxt   = issued_q + {7'd0, mul_ack};
        rcv_nxt   = rcvd_q + {7'd0, psum_ok};
        // Credit is judged on the post-edge count so a tile can start right
        // after the previous one's last round without a bubble.
        credit_ok = (32'(out_nxt) < MAX_OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            tiles_q        <= '0;
            issued_q       <= '0;
            rcvd_q         <= '0;
            outst_q        <= '0;
            rounds_q       <= '0;
            wsize          <= '0;
            stride         <= 1'b0;
            wround         <= '0;
            MUL_DATA_valid <= 1'b0;
            mul_ack        <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            outst_q  <= out_nxt[2:0];
            issued_q <= iss_nxt;
            rcvd_q   <= rcv_nxt;
            done     <= 1'b0;

            // A Psum with nothing in flight is an adder fault; counters hold.
            if (Psum_valid && outst_q == 3'd0) begin
                err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        if (cfg_wsize > WS_7X7) begin
                            err <= 1'b1;
                        end else begin
                            wsize    <= cfg_wsize;
                            stride   <= cfg_stride;
                            tiles_q  <= cfg_tiles;
                            rounds_q <= rounds_per_tile(cfg_wsize, cfg_stride);
                            issued_q <= '0;
                            rcvd_q   <= '0;
                            outst_q  <= '0;
                            if (cfg_tiles == 8'd0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ISSUE;
                            end
                        end
                    end
                end

                ISSUE: begin
                    if (MUL_DATA_valid && !mul_ack) begin
                        // Mid-tile: keep going regardless of mul_avail.
                        wround  <= wround + 3'd1;
                        mul_ack <= ((wround + 3'd1) == (rounds_q - 3'd1));
                    end else if (iss_nxt == tiles_q) begin
                        state          <= DRAIN;
                        MUL_DATA_valid <= 1'b0;
                        wround         <= '0;
                        mul_ack        <= 1'b0;
                    end else if (mul_avail && credit_ok) begin
                        MUL_DATA_valid <= 1'b1;
                        wround         <= '0;
                        mul_ack        <= (rounds_q == 3'd1);
                    end else begin
                        MUL_DATA_valid <= 1'b0;
                        wround         <= '0;
                        mul_ack        <= 1'b0;
                    end
                end

                DRAIN: begin
                    if (rcv_nxt == tiles_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (wdog_expire) begin
                        err   <= 1'b1;
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);

`ifdef ADDER_CTRL_WDOG_EN
    adder_ctrl_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    ((state != DRAIN) || Psum_valid),
        .en     ((state == DRAIN) && !Psum_valid),
        .expire (wdog_expire)
    );
`else
    assign wdog_expire = 1'b0;
`endif

endmodule
